prog_loader: RTL
================

Name: prog_loader

Overview:
- Write-side counterpart to the program-checking flow: streams a program image byte-by-byte into instruction memory while holding the single-cycle RISC-V core in reset.
- Releases the core once loading completes, then watches PC for the end-of-program address or a cycle timeout.
- Sits between an external byte source (UART/host bridge) and the core's instruction memory write port and reset input.

Parameters:
- ADDR_W, 8, word-address width of instruction memory (capacity 2^ADDR_W words).
- FIN_ADDR, 32'h000000bc, PC value that marks program completion.
- TIMEOUT, 50000, maximum core cycles in RUN before declaring failure.
- RST_HOLD, 2, cycles cpu_reset stays high after the last write before release.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset of this block.
- s_valid  in  1  byte stream valid.
- s_data  in  8  byte stream data, little-endian within each 32-bit word.
- s_last  in  1  marks the final byte of the image; qualified by s_valid.
- s_ready  out  1  byte accepted when s_valid && s_ready at a rising edge.
- restart  in  1  single-cycle pulse; returns the block to IDLE from DONE or FAIL.
- imem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  assembled instruction word.
- cpu_reset  out  1  active-high reset driven into the core.
- pc  in  32  core program counter.
- busy  out  1  high in LOAD or RUN.
- done  out  1  sticky; PC reached FIN_ADDR.
- fail  out  1  sticky; timeout or overflow.
- overflow  out  1  sticky; image exceeded capacity.
- word_count  out  ADDR_W+1  number of words written.

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE; s_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; cpu_reset=1; busy=0; done=0; fail=0; overflow=0; word_count=0; byte index=0; cycle counter=0.
- States: IDLE, LOAD, HOLD, RUN, DONE, FAIL.
- IDLE: s_ready=1. The first accepted byte is stored as byte 0 and the block moves to LOAD.
- LOAD byte assembly:
  - Accepted byte k (0..3) goes to bits [8k+7:8k].
  - On acceptance of byte 3, imem_we pulses high in the next cycle with imem_addr=word_count and the assembled word. word_count increments in that same cycle.
  - s_ready stays 1 throughout LOAD; back-to-back bytes every cycle are supported.
- s_last:
  - If accepted on a partial word, the remaining bytes are zero-padded and the word is written the next cycle.
  - If accepted on byte 3, the normal write occurs.
  - s_ready drops to 0 the cycle after s_last is accepted, then the block enters HOLD.
- Overflow:
  - A word completing when word_count==2^ADDR_W is not written (imem_we stays 0).
  - overflow=1 and fail=1; go to FAIL immediately. Further bytes are not accepted.
- HOLD: cpu_reset=1 for RST_HOLD cycles, then cpu_reset=0 and enter RUN. The cycle counter clears on entry to RUN.
- RUN:
  - Each cycle, pc is sampled at the rising edge.
  - pc==FIN_ADDR → DONE, done=1 next cycle; cpu_reset stays 0 so architectural state remains inspectable.
  - Otherwise the counter increments. Reaching TIMEOUT → FAIL, fail=1, cpu_reset=1.
  - If the FIN_ADDR hit and the timeout coincide, the hit wins (DONE).
- DONE/FAIL: s_ready=0, no memory writes, flags hold.
  - restart → IDLE; clears done, fail, overflow, word_count, byte index; cpu_reset=1.
  - restart in any other state is ignored.
- busy = (state==LOAD || state==HOLD || state==RUN).
- Reset asserted mid-operation: state and outputs return to reset values immediately. A partial word is discarded without being written.

Test Plan:
- Stream 8 bytes 13 05 00 00 93 05 10 00 with s_last on the 8th → writes 0x00000513 @0 and 0x00100593 @1; word_count=2; cpu_reset falls exactly 2 cycles after the second write.
- Stream 6 bytes ending with s_last (bytes 5/6 = AA BB) → second word written as 0x0000BBAA; word_count=2.
- After load, drive pc through 0x00,0x04,...,0xbc → done=1 one cycle after pc==0xbc; fail=0; busy=0.
- After load, hold pc at 0x10 with TIMEOUT=100 → fail=1 after 100 RUN cycles; cpu_reset=1.
- With ADDR_W=2, stream 20 bytes → 4 writes; the 5th word is not written; overflow=1, fail=1, s_ready=0.
- Pull reset low after 3 bytes of a word → no imem_we; all outputs at reset values. Then restart from DONE → IDLE, word_count=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: streams a little-endian byte image into instruction memory
// while holding the core in reset, then releases the core and watches its
// PC for the end-of-program address or a cycle timeout.
// RST_HOLD must be at least 1.
module prog_loader #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] FIN_ADDR = 32'h000000bc,
  parameter int          TIMEOUT  = 50000,
  parameter int          RST_HOLD = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  input  logic [31:0]       pc,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic              overflow,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  localparam int HOLD_W = $clog2(RST_HOLD + 1);

  // word_count value at which memory is full
  localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1'b1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HOLD = 3'd2,
    S_RUN  = 3'd3,
    S_DONE = 3'd4,
    S_FAIL = 3'd5
  } state_t;

  state_t              state_r, state_s;
  logic [1:0]          byte_idx_r, byte_idx_s;
  logic [31:0]         word_buf_r, word_buf_s;
  logic [ADDR_W:0]     word_count_r, word_count_s;
  logic [CNT_W-1:0]    cycle_cnt_r, cycle_cnt_s;
  logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic                s_ready_r, s_ready_s;
  logic                imem_we_r, imem_we_s;
  logic [ADDR_W-1:0]   imem_addr_r, imem_addr_s;
  logic [31:0]         imem_wdata_r, imem_wdata_s;
  logic                cpu_reset_r, cpu_reset_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                fail_r, fail_s;
  logic                overflow_r, overflow_s;
  logic                accept_s;
  logic                word_end_s;
  logic [31:0]         merged_s;

  // Next-state and next-output computation for every register
  always_comb begin
    state_s      = state_r;
    byte_idx_s   = byte_idx_r;
    word_buf_s   = word_buf_r;
    word_count_s = word_count_r;
    cycle_cnt_s  = cycle_cnt_r;
    hold_cnt_s   = hold_cnt_r;
    imem_we_s    = 1'b0;
    imem_addr_s  = imem_addr_r;
    imem_wdata_s = imem_wdata_r;
    done_s       = done_r;
    fail_s       = fail_r;
    overflow_s   = overflow_r;
    accept_s     = s_valid && s_ready_r;
    word_end_s   = (byte_idx_r == 2'd3) || s_last;

    // the buffer is cleared after each word, so unfilled bytes are zero
    merged_s = word_buf_r;
    case (byte_idx_r)
      2'd0:    merged_s[7:0]   = s_data;
      2'd1:    merged_s[15:8]  = s_data;
      2'd2:    merged_s[23:16] = s_data;
      2'd3:    merged_s[31:24] = s_data;
      default: merged_s        = word_buf_r;
    endcase

    case (state_r)
      S_IDLE, S_LOAD: begin
        if (accept_s) begin
          state_s = S_LOAD;
          if (word_end_s) begin
            byte_idx_s = 2'd0;
            word_buf_s = 32'h0000_0000;
            if (word_count_r == CAPACITY) begin
              // image larger than memory: drop the word and stop loading
              overflow_s = 1'b1;
              fail_s     = 1'b1;
              state_s    = S_FAIL;
            end else begin
              imem_we_s    = 1'b1;
              imem_addr_s  = word_count_r[ADDR_W-1:0];
              imem_wdata_s = merged_s;
              word_count_s = word_count_r + WC_ONE;
              if (s_last) begin
                state_s    = S_HOLD;
                hold_cnt_s = {HOLD_W{1'b0}};
              end else begin
                state_s = S_LOAD;
              end
            end
          end else begin
            word_buf_s = merged_s;
            byte_idx_s = byte_idx_r + 2'd1;
          end
        end else begin
          state_s = state_r;
        end
      end
      S_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_s     = S_RUN;
          cycle_cnt_s = {CNT_W{1'b0}};
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      S_RUN: begin
        // a PC hit takes priority over a coinciding timeout
        if (pc == FIN_ADDR) begin
          state_s = S_DONE;
          done_s  = 1'b1;
        end else if (cycle_cnt_r == CNT_LAST) begin
          state_s     = S_FAIL;
          fail_s      = 1'b1;
          cycle_cnt_s = cycle_cnt_r + CNT_ONE;
        end else begin
          cycle_cnt_s = cycle_cnt_r + CNT_ONE;
        end
      end
      S_DONE, S_FAIL: begin
        if (restart) begin
          state_s      = S_IDLE;
          done_s       = 1'b0;
          fail_s       = 1'b0;
          overflow_s   = 1'b0;
          word_count_s = {(ADDR_W + 1){1'b0}};
          byte_idx_s   = 2'd0;
          word_buf_s   = 32'h0000_0000;
          cycle_cnt_s  = {CNT_W{1'b0}};
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    // outputs that are pure functions of the upcoming state
    s_ready_s   = (state_s == S_IDLE) || (state_s == S_LOAD);
    busy_s      = (state_s == S_LOAD) || (state_s == S_HOLD) || (state_s == S_RUN);
    cpu_reset_s = !((state_s == S_RUN) || (state_s == S_DONE));
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= S_IDLE;
      byte_idx_r   <= 2'd0;
      word_buf_r   <= 32'h0000_0000;
      word_count_r <= {(ADDR_W + 1){1'b0}};
      cycle_cnt_r  <= {CNT_W{1'b0}};
      hold_cnt_r   <= {HOLD_W{1'b0}};
      s_ready_r    <= 1'b1;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_W{1'b0}};
      imem_wdata_r <= 32'h0000_0000;
      cpu_reset_r  <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      fail_r       <= 1'b0;
      overflow_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      byte_idx_r   <= byte_idx_s;
      word_buf_r   <= word_buf_s;
      word_count_r <= word_count_s;
      cycle_cnt_r  <= cycle_cnt_s;
      hold_cnt_r   <= hold_cnt_s;
      s_ready_r    <= s_ready_s;
      imem_we_r    <= imem_we_s;
      imem_addr_r  <= imem_addr_s;
      imem_wdata_r <= imem_wdata_s;
      cpu_reset_r  <= cpu_reset_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      fail_r       <= fail_s;
      overflow_r   <= overflow_s;
    end
  end

  assign s_ready    = s_ready_r;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_reset  = cpu_reset_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign fail       = fail_r;
  assign overflow   = overflow_r;
  assign word_count = word_count_r;

endmodule
